// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/appender: forwards payload beats unchanged, then appends
// the frame CRC as CRC_W/DATA_W beats (MSB chunk first) and reports it on a side port.
module crc_stream_engine #(
    parameter int               CRC_W       = 16,
    parameter int               DATA_W      = 8,
    parameter logic [CRC_W-1:0] POLY        = 'h8005,
    parameter logic [CRC_W-1:0] INIT        = 'h0000,
    parameter logic [CRC_W-1:0] XOR_OUT     = 'h0000,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter bit               APPEND_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CRC_W-1:0]  crc_value,
    output logic              crc_done
);

    localparam int NCHUNK = CRC_W / DATA_W;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    generate
        if ((CRC_W % DATA_W) != 0) begin : g_bad_width
            $error("crc_stream_engine: CRC_W must be a multiple of DATA_W");
        end
    endgenerate

    typedef enum logic {
        PASS,
        APPEND
    } state_t;

    state_t             state;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   shift_reg;
    logic [CNT_W-1:0]   chunk_cnt;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   crc_final;
    logic               slot_free;
    logic               accept;

    // Bit-serial CRC over one beat, unrolled into a single combinational step.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             b;
        logic             fb;
        c = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            b  = REFLECT_IN ? data[i] : data[DATA_W-1-i];
            fb = c[CRC_W-1] ^ b;
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] bit_reverse(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    assign crc_next  = crc_step(crc_reg, s_data);
    assign crc_final = (REFLECT_OUT ? bit_reverse(crc_next) : crc_next) ^ XOR_OUT;
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (state == PASS) && slot_free && !clear;
    assign accept    = s_valid && s_ready;

    // Single output register; clear drops any pending beat and restarts the CRC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PASS;
            crc_reg   <= INIT;
            shift_reg <= '0;
            chunk_cnt <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            crc_value <= '0;
            crc_done  <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            if (clear) begin
                state     <= PASS;
                crc_reg   <= INIT;
                chunk_cnt <= '0;
                m_valid   <= 1'b0;
                m_last    <= 1'b0;
            end else begin
                if (m_ready) begin
                    m_valid <= 1'b0;
                end
                case (state)
                    PASS: begin
                        if (accept) begin
                            m_valid <= 1'b1;
                            m_data  <= s_data;
                            m_last  <= s_last && !APPEND_EN;
                            if (s_last) begin
                                crc_value <= crc_final;
                                crc_done  <= 1'b1;
                                crc_reg   <= INIT;
                                if (APPEND_EN) begin
                                    shift_reg <= crc_final;
                                    chunk_cnt <= CNT_W'(NCHUNK);
                                    state     <= APPEND;
                                end
                            end else begin
                                crc_reg <= crc_next;
                            end
                        end
                    end
                    APPEND: begin
                        if (slot_free) begin
                            m_valid   <= 1'b1;
                            m_data    <= shift_reg[CRC_W-1 -: DATA_W];
                            m_last    <= (chunk_cnt == CNT_W'(1));
                            shift_reg <= shift_reg << DATA_W;
                            chunk_cnt <= chunk_cnt - CNT_W'(1);
                            if (chunk_cnt == CNT_W'(1)) begin
                                state <= PASS;
                            end
                        end
                    end
                    default: state <= PASS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: three configurations (CRC-16/BUYPASS, CRC-16/CCITT-FALSE,
// CRC-32) share one input stream and are checked against hand-computed CRCs of "123456789".
module tb_crc_stream_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready = 1'b1;
    bit         rand_ready = 1'b0;

    logic        s_ready0, s_ready1, s_ready2;
    logic        m_valid0, m_valid1, m_valid2;
    logic [7:0]  m_data0, m_data1, m_data2;
    logic        m_last0, m_last1, m_last2;
    logic [15:0] crc0, crc1;
    logic [31:0] crc2;
    logic        done0, done1, done2;

    logic [7:0] msg [9];
    int checks = 0;
    int failures = 0;

    crc_stream_engine dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
        .crc_value(crc0), .crc_done(done0)
    );

    crc_stream_engine #(.POLY('h1021), .INIT('hFFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
        .crc_value(crc1), .crc_done(done1)
    );

    crc_stream_engine #(.CRC_W(32), .POLY('h04C11DB7), .INIT('hFFFFFFFF), .XOR_OUT('hFFFFFFFF),
                        .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2),
        .crc_value(crc2), .crc_done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: records transferred beats, crc_done pulses and stall stability of dut0.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    int         done_cnt [3];
    int         done_double = 0;
    int         stall_viol = 0;
    logic       stalled = 1'b0;
    logic [8:0] stall_beat;
    logic [2:0] prev_done = 3'b000;

    initial begin
        for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled   = 1'b0;
            prev_done = 3'b000;
        end else begin
            if (stalled && !(m_valid0 && {m_last0, m_data0} == stall_beat)) stall_viol++;
            stalled    = m_valid0 && !m_ready && !clear;
            stall_beat = {m_last0, m_data0};
            if (m_valid0 && m_ready) q0.push_back({m_last0, m_data0});
            if (m_valid1 && m_ready) q1.push_back({m_last1, m_data1});
            if (m_valid2 && m_ready) q2.push_back({m_last2, m_data2});
            if (done0) done_cnt[0]++;
            if (done1) done_cnt[1]++;
            if (done2) done_cnt[2]++;
            if ((prev_done & {done2, done1, done0}) != 3'b000) done_double++;
            prev_done = {done2, done1, done0};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives msg[first +: count]; each accepted beat must show on dut0's output one cycle later.
    task automatic applyStimulus(input int first, input int count, input bit with_last);
        for (int i = first; i < first + count; i++) begin
            int waited = 0;
            bit taken  = 1'b0;
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = with_last && (i == first + count - 1);
            while (!taken && waited < 200) begin
                @(negedge clk);
                taken = s_ready0;
                @(posedge clk);
                #1;
                waited++;
            end
            if (taken) begin
                checkOutput($sformatf("latency_valid[%0d]", i), 32'(m_valid0), 32'd1);
                checkOutput($sformatf("latency_data[%0d]", i), 32'(m_data0), 32'(msg[i]));
                checkOutput($sformatf("payload_last[%0d]", i), 32'(m_last0), 32'd0);
                if (s_last) checkOutput("done_pulse", 32'(done0), 32'd1);
            end else begin
                checkOutput($sformatf("accept_timeout[%0d]", i), 32'd0, 32'd1);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bit idle = 1'b0;
        while (!idle && n < 300) begin
            @(negedge clk);
            idle = !m_valid0 && !m_valid1 && !m_valid2;
            n++;
        end
        if (!idle) checkOutput("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] q_beat(input int idx, input int k);
        case (idx)
            0:       return q0[k];
            1:       return q1[k];
            default: return q2[k];
        endcase
    endfunction

    // Expected frame: the nine payload bytes, then the CRC bytes MSB first with m_last on the final one.
    task automatic check_seq(input string tag, input int idx, input int base,
                             input logic [31:0] crc, input int nbytes);
        logic [8:0] exp_beat;
        int         got_len;
        got_len = q_size(idx) - base;
        checkOutput({tag, "_len"}, 32'(got_len), 32'(9 + nbytes));
        for (int k = 0; k < 9 + nbytes; k++) begin
            if (k < 9) exp_beat = {1'b0, msg[k]};
            else       exp_beat = {(k == 8 + nbytes), crc[(nbytes - 1 - (k - 9)) * 8 +: 8]};
            if (k < got_len)
                checkOutput($sformatf("%s_beat[%0d]", tag, k), 32'(q_beat(idx, base + k)), 32'(exp_beat));
        end
    endtask

    int b0, b1, b2;
    int d0, d1, d2;
    bit found;

    task automatic snapshot();
        b0 = q0.size(); b1 = q1.size(); b2 = q2.size();
        d0 = done_cnt[0]; d1 = done_cnt[1]; d2 = done_cnt[2];
    endtask

    task automatic check_frame(input string tag);
        check_seq({tag, "_buypass"}, 0, b0, 32'h0000FEE8, 2);
        check_seq({tag, "_ccitt"},   1, b1, 32'h000029B1, 2);
        check_seq({tag, "_crc32"},   2, b2, 32'hCBF43926, 4);
        checkOutput({tag, "_crc_buypass"}, 32'(crc0), 32'h0000FEE8);
        checkOutput({tag, "_crc_ccitt"},   32'(crc1), 32'h000029B1);
        checkOutput({tag, "_crc32"},       crc2,      32'hCBF43926);
        checkOutput({tag, "_done_cnt0"}, 32'(done_cnt[0] - d0), 32'd1);
        checkOutput({tag, "_done_cnt1"}, 32'(done_cnt[1] - d1), 32'd1);
        checkOutput({tag, "_done_cnt2"}, 32'(done_cnt[2] - d2), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        rst_n   = 1'b0;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", 32'(m_valid0), 32'd0);
        checkOutput("rst_m_data",  32'(m_data0),  32'd0);
        checkOutput("rst_m_last",  32'(m_last0),  32'd0);
        checkOutput("rst_crc",     32'(crc0),     32'd0);
        checkOutput("rst_crc32",   crc2,          32'd0);
        checkOutput("rst_done",    32'(done0),    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_s_ready", 32'(s_ready0), 32'd1);

        $display("[TB] frame with m_ready held high");
        snapshot();
        applyStimulus(0, 9, 1'b1);
        wait_idle();
        check_frame("plain");

        $display("[TB] frame with random m_ready");
        rand_ready = 1'b1;
        snapshot();
        applyStimulus(0, 9, 1'b1);
        wait_idle();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_frame("stall");

        $display("[TB] clear after four bytes");
        applyStimulus(0, 4, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        s_last  = 1'b1;
        clear   = 1'b1;
        #1;
        checkOutput("clear_s_ready", 32'(s_ready0), 32'd0);
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("clear_m_valid", 32'(m_valid0), 32'd0);
        checkOutput("clear_crc_kept", 32'(crc0), 32'h0000FEE8);
        repeat (2) @(posedge clk);
        #1;
        snapshot();
        checkOutput("clear_no_done", 32'(done0), 32'd0);
        applyStimulus(0, 9, 1'b1);
        wait_idle();
        check_frame("after_clear");

        $display("[TB] reset during append");
        applyStimulus(0, 9, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk);
            #1;
            found = m_valid0 && (m_data0 == 8'hFE);
        end
        checkOutput("fe_seen", 32'(found), 32'd1);
        checkOutput("append_s_ready", 32'(s_ready0), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_m_valid", 32'(m_valid0), 32'd0);
        checkOutput("midrst_crc",     32'(crc0),     32'd0);
        checkOutput("midrst_crc32",   crc2,          32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        snapshot();
        applyStimulus(0, 9, 1'b1);
        wait_idle();
        check_frame("after_rst");

        checkOutput("stall_stable", 32'(stall_viol), 32'd0);
        checkOutput("done_single",  32'(done_double), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised streaming CRC generator/appender. Successor to the fixed CRC-16 byte engine; polynomial, width, init, reflection and final XOR are now parameters.
- Sits inline on a valid/ready byte/word stream and forwards payload beats unchanged.
- After the frame's last beat it appends the CRC as CRC_W/DATA_W extra beats, MSB chunk first, and also reports the CRC on a side port.

Parameters:
- CRC_W, 16: CRC register width; must be a multiple of DATA_W (elaboration error otherwise).
- DATA_W, 8: stream beat width; one beat is absorbed per clock.
- POLY, 'h8005: generator polynomial, implicit x^CRC_W term omitted.
- INIT, 'h0000: CRC register value at frame start.
- XOR_OUT, 'h0000: value XORed into the final CRC.
- REFLECT_IN, 0: 1 = process each input beat LSB-first.
- REFLECT_OUT, 0: 1 = bit-reverse the final CRC before XOR_OUT.
- APPEND_EN, 1: 1 = append CRC beats to the output stream; 0 = pass-through only (m_last on the payload's last beat).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous abort: drops the frame and reloads INIT.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  DATA_W  payload beat.
- s_last  in  1  final payload beat of the frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  payload or CRC chunk.
- m_last  out  1  final beat of the output frame.
- crc_value  out  CRC_W  final CRC of the last completed frame.
- crc_done  out  1  one-cycle pulse when crc_value updates.

Behaviour:
- Reset values: state PASS, crc_reg=INIT, m_valid=0, m_data=0, m_last=0, crc_value=0, crc_done=0, chunk counter=0.
- Reset is asynchronous on all flops. Reset or clear mid-frame discards the partial frame and any pending output beat, and emits nothing further for that frame.
- Output stage is one register. s_ready = (state==PASS) & (!m_valid | m_ready).
- Latency: an accepted beat appears on m_data the next cycle. With m_ready held high, throughput is 1 beat/clock.
- m_valid/m_data/m_last are held stable while m_valid & !m_ready.
- CRC update (combinational, one beat per cycle):
  - Iterate DATA_W bits, MSB-first, or LSB-first if REFLECT_IN.
  - Per bit: fb = crc[CRC_W-1] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0).
  - All arithmetic is modulo CRC_W bits.
- final = (REFLECT_OUT ? bitrev(crc_next) : crc_next) ^ XOR_OUT, where crc_next includes the last beat.
- State PASS:
  - On an accepted beat: crc_reg <= crc_next; forward the beat with m_last = s_last & !APPEND_EN.
  - If that beat has s_last: crc_value <= final; crc_done=1 for one cycle; crc_reg <= INIT.
  - Then, if APPEND_EN: latch final into the shift register, chunk counter <= CRC_W/DATA_W, go to APPEND.
- State APPEND:
  - s_ready=0.
  - Whenever the output slot is free (!m_valid | m_ready), load the top DATA_W bits of the shift register onto m_data, shift left by DATA_W, and decrement the counter.
  - The last chunk carries m_last=1. After loading it, return to PASS; the next frame may be accepted only once that beat drains.
- Single-beat frames (s_valid & s_last on the first beat) are legal, and the CRC covers that one beat.
- clear has priority over a simultaneous input handshake: the beat is not consumed into the CRC, and s_ready is forced to 0 in the clear cycle.
- crc_done and the side port do not depend on m_ready.

Test Plan:
- Defaults, ASCII "123456789" (0x31..0x39, s_last on 0x39), m_ready=1 → payload out 1 cycle delayed, then 0xFE, 0xE8 with m_last on 0xE8; crc_value=0xFEE8, crc_done pulse once.
- POLY='h1021, INIT='hFFFF, same bytes → crc_value=0x29B1, appended beats 0x29, 0xB1.
- CRC_W=32, POLY='h04C11DB7, INIT/XOR_OUT='hFFFFFFFF, REFLECT_IN/OUT=1 → crc_value=0xCBF43926, four appended beats CB F4 39 26.
- Defaults, m_ready toggled randomly (about 50%) during payload and append → identical output sequence to the first scenario, with no beat dropped or duplicated and m_data stable while stalled.
- Assert clear after 4 bytes of a frame, then send "123456789" → only the second frame is emitted; crc_value=0xFEE8; no crc_done pulse for the aborted frame.
- Assert rst_n low during the APPEND state after the 0xFE beat → m_valid=0 and crc_value=0 immediately; the next frame computes correctly from INIT.
